// File: rtl/writeback_regfile.sv
// writeback_regfile
//   Write-back end of the register bank: owns the 32x32 architectural registers
//   read by decode, commits MEM/WB results and keeps a per-register count of
//   in-flight writes so decode can be held on RAW hazards and counter saturation.
//   Optional build macro: WB_BYPASS_EN -- forward write-back data onto the rN
//   outputs in the write-back cycle and release a stall on a source whose last
//   pending write is landing in that same cycle.
module writeback_regfile #(
  parameter int          NREG    = 32,
  parameter int          CNT_W   = 2,
  parameter logic [31:0] RST_VAL = 32'h0000_0000
) (
  input  logic        clk_46,
  input  logic        rst_46,
  input  logic        iss_valid_46,
  input  logic [31:0] iss_IR_46,
  input  logic        wb_valid_46,
  input  logic [4:0]  wb_reg_46,
  input  logic [31:0] wb_data_46,
  output logic        stall_46,
  output logic        wb_err_46,
  output logic [31:0] r0,  r1,  r2,  r3,  r4,  r5,  r6,  r7,
  output logic [31:0] r8,  r9,  r10, r11, r12, r13, r14, r15,
  output logic [31:0] r16, r17, r18, r19, r20, r21, r22, r23,
  output logic [31:0] r24, r25, r26, r27, r28, r29, r30, r31
);

  localparam logic [5:0] OP_ADD  = 6'b110001;
  localparam logic [5:0] OP_MUL  = 6'b100111;
  localparam logic [5:0] OP_ADDI = 6'b000100;
  localparam logic [5:0] OP_LDW  = 6'b010111;
  localparam logic [5:0] OP_STW  = 6'b010101;
  localparam logic [5:0] OP_BLT  = 6'b010110;
  localparam logic [5:0] OP_BEQ  = 6'b100110;

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1'b1);

  logic [5:0]       opcode_s;
  logic [4:0]       src_s, dest_s, targ_s;
  logic             rd_src_s, rd_dst_s, wr_en_s;
  logic [4:0]       wr_idx_s;
  logic             src_busy_s, dst_busy_s, sat_s, stall_s, accept_s;
  logic             wb_spur_s, wb_err_r;
  logic [CNT_W-1:0] cnt_v_s  [NREG];
  logic [31:0]      view_s   [NREG];
  logic             ir_unused_s;

  assign opcode_s    = iss_IR_46[5:0];
  assign src_s       = iss_IR_46[31:27];
  assign dest_s      = iss_IR_46[26:22];
  assign targ_s      = iss_IR_46[21:17];
  assign ir_unused_s = ^iss_IR_46[16:6];

  // Decode which operands the presented instruction reads and where it writes.
  always_comb begin
    rd_src_s = 1'b0;
    rd_dst_s = 1'b0;
    wr_en_s  = 1'b0;
    wr_idx_s = 5'd0;
    case (opcode_s)
      OP_ADD, OP_MUL: begin
        rd_src_s = 1'b1;
        rd_dst_s = 1'b1;
        wr_en_s  = 1'b1;
        wr_idx_s = targ_s;
      end
      OP_ADDI, OP_LDW: begin
        rd_src_s = 1'b1;
        wr_en_s  = 1'b1;
        wr_idx_s = dest_s;
      end
      OP_STW, OP_BLT, OP_BEQ: begin
        rd_src_s = 1'b1;
        rd_dst_s = 1'b1;
      end
      default: begin
        // BR, NOPE and unknown opcodes neither read nor write the bank.
        rd_src_s = 1'b0;
      end
    endcase
  end

  // Hazard detection from registered counters; issue is accepted only without a stall.
  always_comb begin
    src_busy_s = (cnt_v_s[src_s]  != CNT_ZERO);
    dst_busy_s = (cnt_v_s[dest_s] != CNT_ZERO);
`ifdef WB_BYPASS_EN
    // The last outstanding write landing this cycle is forwarded, so it no longer blocks.
    src_busy_s = src_busy_s && !(wb_valid_46 && (wb_reg_46 == src_s)  && (cnt_v_s[src_s]  == CNT_ONE));
    dst_busy_s = dst_busy_s && !(wb_valid_46 && (wb_reg_46 == dest_s) && (cnt_v_s[dest_s] == CNT_ONE));
`endif
    sat_s    = wr_en_s && (cnt_v_s[wr_idx_s] == CNT_MAX);
    stall_s  = iss_valid_46 && ((rd_src_s && src_busy_s) || (rd_dst_s && dst_busy_s) || sat_s);
    accept_s = iss_valid_46 && !stall_s;
  end

  assign stall_46  = stall_s;
  assign wb_spur_s = wb_valid_46 && (cnt_v_s[wb_reg_46] == CNT_ZERO);

  for (genvar gi = 0; gi < NREG; gi++) begin : g_reg
    logic [31:0]      reg_r;
    logic [CNT_W-1:0] cnt_r;
    logic             inc_s, wb_hit_s, dec_s;

    // Per-register scoreboard events: accepted issue targeting it, write-back hitting it.
    always_comb begin
      inc_s    = accept_s && wr_en_s && (wr_idx_s == 5'(gi));
      wb_hit_s = wb_valid_46 && (wb_reg_46 == 5'(gi));
      dec_s    = wb_hit_s && (cnt_r != CNT_ZERO);
    end

    // Bank entry and its pending-write counter; +1 and -1 in the same cycle cancel.
    always_ff @(posedge clk_46 or negedge rst_46) begin
      if (!rst_46) begin
        reg_r <= RST_VAL;
        cnt_r <= CNT_ZERO;
      end else begin
        if (wb_hit_s) begin
          reg_r <= wb_data_46;
        end else begin
          reg_r <= reg_r;
        end
        case ({inc_s, dec_s})
          2'b10:   cnt_r <= cnt_r + CNT_ONE;
          2'b01:   cnt_r <= cnt_r - CNT_ONE;
          default: cnt_r <= cnt_r;
        endcase
      end
    end

    assign cnt_v_s[gi] = cnt_r;
`ifdef WB_BYPASS_EN
    assign view_s[gi] = wb_hit_s ? wb_data_46 : reg_r;
`else
    assign view_s[gi] = reg_r;
`endif
  end

  // Sticky flag for a write-back that had no matching in-flight issue.
  always_ff @(posedge clk_46 or negedge rst_46) begin
    if (!rst_46) begin
      wb_err_r <= 1'b0;
    end else if (wb_spur_s) begin
      wb_err_r <= 1'b1;
    end else begin
      wb_err_r <= wb_err_r;
    end
  end

  assign wb_err_46 = wb_err_r;

  assign r0  = view_s[0];  assign r1  = view_s[1];  assign r2  = view_s[2];  assign r3  = view_s[3];
  assign r4  = view_s[4];  assign r5  = view_s[5];  assign r6  = view_s[6];  assign r7  = view_s[7];
  assign r8  = view_s[8];  assign r9  = view_s[9];  assign r10 = view_s[10]; assign r11 = view_s[11];
  assign r12 = view_s[12]; assign r13 = view_s[13]; assign r14 = view_s[14]; assign r15 = view_s[15];
  assign r16 = view_s[16]; assign r17 = view_s[17]; assign r18 = view_s[18]; assign r19 = view_s[19];
  assign r20 = view_s[20]; assign r21 = view_s[21]; assign r22 = view_s[22]; assign r23 = view_s[23];
  assign r24 = view_s[24]; assign r25 = view_s[25]; assign r26 = view_s[26]; assign r27 = view_s[27];
  assign r28 = view_s[28]; assign r29 = view_s[29]; assign r30 = view_s[30]; assign r31 = view_s[31];

endmodule

// File: tb/tb_writeback_regfile.sv
// tb_writeback_regfile
//   Scoreboard bench: the stimulus process computes the expected stall, error flag
//   and register view from a reference model of the pending-write rules and queues
//   it; a negedge monitor pops each entry and compares it with the DUT outputs.
`timescale 1ns/1ps
module tb_writeback_regfile;

  localparam logic [5:0] OP_ADD  = 6'b110001;
  localparam logic [5:0] OP_MUL  = 6'b100111;
  localparam logic [5:0] OP_ADDI = 6'b000100;
  localparam logic [5:0] OP_LDW  = 6'b010111;
  localparam logic [5:0] OP_STW  = 6'b010101;
  localparam logic [5:0] OP_BLT  = 6'b010110;
  localparam logic [5:0] OP_BEQ  = 6'b100110;
  localparam logic [5:0] OP_BR   = 6'b000110;
  localparam logic [5:0] OP_NOPE = 6'b111111;
  localparam int         MAX_PEND = 3;
`ifdef WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk_46       = 1'b0;
  logic        rst_46       = 1'b0;
  logic        iss_valid_46 = 1'b0;
  logic [31:0] iss_IR_46    = 32'd0;
  logic        wb_valid_46  = 1'b0;
  logic [4:0]  wb_reg_46    = 5'd0;
  logic [31:0] wb_data_46   = 32'd0;
  logic        stall_46, wb_err_46;
  logic [31:0] r_o [32];

  writeback_regfile dut (
    .clk_46(clk_46), .rst_46(rst_46), .iss_valid_46(iss_valid_46), .iss_IR_46(iss_IR_46),
    .wb_valid_46(wb_valid_46), .wb_reg_46(wb_reg_46), .wb_data_46(wb_data_46),
    .stall_46(stall_46), .wb_err_46(wb_err_46),
    .r0(r_o[0]),   .r1(r_o[1]),   .r2(r_o[2]),   .r3(r_o[3]),   .r4(r_o[4]),   .r5(r_o[5]),
    .r6(r_o[6]),   .r7(r_o[7]),   .r8(r_o[8]),   .r9(r_o[9]),   .r10(r_o[10]), .r11(r_o[11]),
    .r12(r_o[12]), .r13(r_o[13]), .r14(r_o[14]), .r15(r_o[15]), .r16(r_o[16]), .r17(r_o[17]),
    .r18(r_o[18]), .r19(r_o[19]), .r20(r_o[20]), .r21(r_o[21]), .r22(r_o[22]), .r23(r_o[23]),
    .r24(r_o[24]), .r25(r_o[25]), .r26(r_o[26]), .r27(r_o[27]), .r28(r_o[28]), .r29(r_o[29]),
    .r30(r_o[30]), .r31(r_o[31])
  );

  always #5 clk_46 = ~clk_46;

  typedef struct packed {
    logic             stall;
    logic             err;
    logic [31:0][31:0] regs;
  } exp_t;

  exp_t        sb_q [$];
  exp_t        mon_e;
  int          n_checks = 0;
  int          n_pass   = 0;
  logic [31:0] m_reg [32];
  int          m_cnt [32];
  bit          m_err;
  logic [5:0]  op_tab [10] = '{OP_ADD, OP_MUL, OP_ADDI, OP_LDW, OP_STW,
                               OP_BLT, OP_BEQ, OP_BR, OP_NOPE, 6'b000000};

  function automatic logic [31:0] mk(input logic [5:0] op, input logic [4:0] s,
                                     input logic [4:0] d, input logic [4:0] t);
    return {s, d, t, 11'h5A5, op};
  endfunction

  // Architectural meaning of an instruction: destination (-1 none) and up to two sources.
  function automatic void decode(input logic [31:0] ir, output int dst, output int s0, output int s1);
    dst = -1; s0 = -1; s1 = -1;
    case (ir[5:0])
      OP_ADD, OP_MUL:         begin dst = int'(ir[21:17]); s0 = int'(ir[31:27]); s1 = int'(ir[26:22]); end
      OP_ADDI, OP_LDW:        begin dst = int'(ir[26:22]); s0 = int'(ir[31:27]); end
      OP_STW, OP_BLT, OP_BEQ: begin s0 = int'(ir[31:27]); s1 = int'(ir[26:22]); end
      default:                begin dst = -1; end
    endcase
  endfunction

  function automatic bit pending(input int s, input bit wv, input logic [4:0] wr);
    if (m_cnt[s] == 0) return 1'b0;
    if (BYP && m_cnt[s] == 1 && wv && int'(wr) == s) return 1'b0;
    return 1'b1;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, act, expv, $time);
  endtask

  // One cycle: drive inputs, queue the expected outputs, then advance the model.
  task automatic step(input bit iv, input logic [31:0] ir, input bit wv,
                      input logic [4:0] wr, input logic [31:0] wd);
    int dst, s0, s1;
    bit stl;
    exp_t e;
    iss_valid_46 = iv; iss_IR_46 = ir;
    wb_valid_46 = wv; wb_reg_46 = wr; wb_data_46 = wd;
    decode(ir, dst, s0, s1);
    stl = 1'b0;
    if (iv) begin
      if (s0 >= 0 && pending(s0, wv, wr)) stl = 1'b1;
      if (s1 >= 0 && pending(s1, wv, wr)) stl = 1'b1;
      if (dst >= 0 && m_cnt[dst] == MAX_PEND) stl = 1'b1;
    end
    e.stall = stl;
    e.err   = m_err;
    for (int i = 0; i < 32; i++) e.regs[i] = (BYP && wv && int'(wr) == i) ? wd : m_reg[i];
    sb_q.push_back(e);
    if (wv) begin
      if (m_cnt[wr] == 0) m_err = 1'b1;
      else m_cnt[wr] = m_cnt[wr] - 1;
      m_reg[wr] = wd;
    end
    if (iv && !stl && dst >= 0) m_cnt[dst] = m_cnt[dst] + 1;
    @(posedge clk_46); #1;
  endtask

  // Reset asserted for one cycle; its effect is expected immediately.
  task automatic do_reset();
    exp_t e;
    rst_46 = 1'b0; iss_valid_46 = 1'b1; iss_IR_46 = mk(OP_ADD, 5'd1, 5'd2, 5'd3);
    wb_valid_46 = 1'b0;
    for (int i = 0; i < 32; i++) begin m_reg[i] = 32'd0; m_cnt[i] = 0; end
    m_err = 1'b0;
    e.stall = 1'b0; e.err = 1'b0; e.regs = '0;
    sb_q.push_back(e);
    @(posedge clk_46); #1;
    rst_46 = 1'b1; iss_valid_46 = 1'b0;
  endtask

  task automatic rand_step();
    logic [5:0]  op;
    logic [4:0]  wr;
    bit          iv, wv;
    op = op_tab[$urandom_range(0, 9)];
    iv = ($urandom_range(0, 3) != 0);
    wv = ($urandom_range(0, 2) != 0);
    wr = 5'($urandom_range(0, 7));
    if (m_cnt[wr] == 0 && $urandom_range(0, 15) != 0) wv = 1'b0;
    step(iv, mk(op, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))),
         wv, wr, $urandom);
  endtask

  // Monitor: compare each queued expectation with the DUT away from the active edge.
  always @(negedge clk_46) begin
    if (sb_q.size() != 0) begin
      mon_e = sb_q.pop_front();
      chk("stall", 32'(stall_46), 32'(mon_e.stall));
      chk("wb_err", 32'(wb_err_46), 32'(mon_e.err));
      for (int i = 0; i < 32; i++) chk($sformatf("r%0d", i), r_o[i], mon_e.regs[i]);
    end
  end

  initial begin
    @(posedge clk_46); #1;
    do_reset();
    // basic write: ADDI dest=R5, then write-back
    step(1'b1, mk(OP_ADDI, 5'd1, 5'd5, 5'd0), 1'b0, 5'd0, 32'd0);
    step(1'b0, 32'd0, 1'b1, 5'd5, 32'h0000_1234);
    step(1'b1, mk(OP_ADD, 5'd5, 5'd6, 5'd10), 1'b0, 5'd0, 32'd0);
    // RAW on R7
    step(1'b1, mk(OP_ADD, 5'd1, 5'd2, 5'd7), 1'b0, 5'd0, 32'd0);
    repeat (3) step(1'b1, mk(OP_ADD, 5'd7, 5'd2, 5'd8), 1'b0, 5'd0, 32'd0);
    step(1'b1, mk(OP_ADD, 5'd7, 5'd2, 5'd8), 1'b1, 5'd7, 32'hCAFE_0007);
    step(1'b1, mk(OP_ADD, 5'd7, 5'd2, 5'd11), 1'b0, 5'd0, 32'd0);
    // saturation on R9
    repeat (4) step(1'b1, mk(OP_LDW, 5'd1, 5'd9, 5'd0), 1'b0, 5'd0, 32'd0);
    step(1'b1, mk(OP_LDW, 5'd1, 5'd9, 5'd0), 1'b1, 5'd9, 32'h0000_0909);
    step(1'b1, mk(OP_LDW, 5'd1, 5'd9, 5'd0), 1'b0, 5'd0, 32'd0);
    step(1'b1, mk(OP_LDW, 5'd1, 5'd9, 5'd0), 1'b0, 5'd0, 32'd0);
    // simultaneous issue and write-back on R3
    step(1'b1, mk(OP_MUL, 5'd1, 5'd0, 5'd3), 1'b0, 5'd0, 32'd0);
    step(1'b1, mk(OP_MUL, 5'd1, 5'd0, 5'd3), 1'b1, 5'd3, 32'h3333_0003);
    step(1'b1, mk(OP_ADD, 5'd3, 5'd1, 5'd4), 1'b0, 5'd0, 32'd0);
    step(1'b1, mk(OP_ADD, 5'd3, 5'd1, 5'd4), 1'b0, 5'd0, 32'd0);
    // spurious write-back on R12, then non-writing instructions
    step(1'b0, 32'd0, 1'b1, 5'd12, 32'h1212_1212);
    step(1'b1, mk(OP_STW, 5'd1, 5'd2, 5'd12), 1'b0, 5'd0, 32'd0);
    step(1'b1, mk(OP_BR, 5'd9, 5'd9, 5'd9), 1'b0, 5'd0, 32'd0);
    step(1'b1, mk(OP_BEQ, 5'd1, 5'd2, 5'd12), 1'b0, 5'd0, 32'd0);
    step(1'b1, mk(OP_NOPE, 5'd9, 5'd3, 5'd9), 1'b0, 5'd0, 32'd0);
    step(1'b0, 32'd0, 1'b0, 5'd0, 32'd0);
    // reset mid-run with writes still pending
    do_reset();
    step(1'b1, mk(OP_ADD, 5'd9, 5'd3, 5'd1), 1'b0, 5'd0, 32'd0);
    repeat (400) rand_step();
    do_reset();
    repeat (100) rand_step();
    @(negedge clk_46); #1;
    chk("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
